// File: rtl/polyphase_interp_fir_if.sv
// Stream and coefficient-load signals for the polyphase interpolating FIR.
// The slave modport is the filter; the master modport is the producer/consumer side.
interface polyphase_interp_fir_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int L      = 4,
  parameter int TPP    = 4
);
  localparam int A_W = $clog2(L*TPP);

  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_last;
  logic                     coef_we;
  logic [A_W-1:0]           coef_addr;
  logic signed [COEF_W-1:0] coef_data;

  modport master (
    output s_valid, s_data, m_ready, coef_we, coef_addr, coef_data,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready, coef_we, coef_addr, coef_data,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/polyphase_interp_fir.sv
// Polyphase interpolating FIR: one input sample produces L phase outputs, one per cycle.
// Optional POLY_INTERP_ROUND_EN adds round-half-up before the output shift (default: floor).
module polyphase_interp_fir #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int L      = 4,
  parameter int TPP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  polyphase_interp_fir_if.slave bus
);
  localparam int A_W   = $clog2(L*TPP);
  localparam int PH_W  = $clog2(L);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TPP);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W-1)));

  // state | meaning: S_IDLE | waiting for a sample ; S_RUN | presenting phase r_phase of the group
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   r_state, w_state_next;
  logic [PH_W-1:0]          r_phase, w_psel;
  logic signed [DATA_W-1:0] r_line [TPP];
  logic signed [DATA_W-1:0] w_line [TPP];
  logic signed [COEF_W-1:0] r_coef [L*TPP];
  logic signed [DATA_W-1:0] r_m_data, w_result;
  logic signed [ACC_W-1:0]  w_acc, w_acc_r, w_shift;
  logic                     w_s_ready, w_m_valid, w_m_last;
  logic                     w_last_phase, w_s_hs, w_m_hs, w_adv;

  assign w_last_phase = (r_phase == PH_W'(L-1));
  assign w_s_hs       = bus.s_valid & w_s_ready;
  assign w_m_hs       = w_m_valid & bus.m_ready;
  assign w_adv        = w_m_hs & ~w_last_phase;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_s_hs) w_state_next = S_RUN;
      S_RUN:   if (w_m_hs && w_last_phase && !bus.s_valid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_m_valid = 1'b0;
    w_m_last  = 1'b0;
    case (r_state)
      S_IDLE: w_s_ready = 1'b1;
      S_RUN: begin
        w_m_valid = 1'b1;
        w_m_last  = w_last_phase;
        w_s_ready = w_last_phase & bus.m_ready;
      end
      default: ;
    endcase
  end

  // The MAC sees the post-shift line when a sample is being accepted this cycle.
  always_comb begin
    for (int t = 0; t < TPP; t++) w_line[t] = r_line[t];
    if (w_s_hs) begin
      w_line[0] = bus.s_data;
      for (int t = 1; t < TPP; t++) w_line[t] = r_line[t-1];
    end
  end

  assign w_psel = w_s_hs ? '0 : r_phase + 1'b1;

  always_comb begin
    w_acc = '0;
    for (int t = 0; t < TPP; t++)
      w_acc = w_acc + ACC_W'(r_coef[A_W'(t*L) + A_W'(w_psel)]) * ACC_W'(w_line[t]);
  end

`ifdef POLY_INTERP_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (COEF_W-2));
  assign w_acc_r = w_acc + RND;
`else
  assign w_acc_r = w_acc;
`endif

  assign w_shift = w_acc_r >>> (COEF_W-1);

  always_comb begin
    if (w_shift > SAT_MAX)      w_result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_result = {1'b1, {(DATA_W-1){1'b0}}};
    else                        w_result = DATA_W'(w_shift);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= '0;
      r_m_data <= '0;
      for (int t = 0; t < TPP; t++) r_line[t] <= '0;
    end else if (w_s_hs) begin
      r_phase  <= '0;
      r_m_data <= w_result;
      for (int t = 0; t < TPP; t++) r_line[t] <= w_line[t];
    end else if (w_adv) begin
      r_phase  <= r_phase + 1'b1;
      r_m_data <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < L*TPP; k++) r_coef[k] <= '0;
    end else if (bus.coef_we) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = w_m_last;
endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Directed bench for polyphase_interp_fir: impulse responses, backpressure, saturation,
// reset mid-group, coefficient-write timing and the POLY_INTERP_ROUND_EN rounding option.
module tb_polyphase_interp_fir;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int L      = 4;
  localparam int TPP    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  polyphase_interp_fir_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .L(L), .TPP(TPP)) bus ();

  polyphase_interp_fir #(.DATA_W(DATA_W), .COEF_W(COEF_W), .L(L), .TPP(TPP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] in_q[$];
  logic signed [15:0] out_q[$];
  logic               last_q[$];
  int                 cyc_q[$];
  int                 stable_err;
  int                 sready_err;
  bit                 timed_out;

  task automatic apply_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_coef(input int a, input logic signed [15:0] v);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(a);
    bus.coef_data = v;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic load_phase_order_coefs();
    for (int k = 0; k < L*TPP; k++) write_coef(k, 16'(k*256));
  endtask

  // Feeds in_q and records output handshakes until max_out outputs or the cycle budget runs out.
  task automatic drive_stream(input int max_out, input bit rnd);
    int idx = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic signed [15:0] prev_d = '0;
    logic prev_l = 1'b0;
    out_q.delete(); last_q.delete(); cyc_q.delete();
    stable_err = 0; sready_err = 0; timed_out = 1'b0;
    while (out_q.size() < max_out) begin
      if (cyc >= 500) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      bus.s_valid = (idx < in_q.size());
      bus.s_data  = (idx < in_q.size()) ? in_q[idx] : '0;
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && (bus.m_data !== prev_d || bus.m_last !== prev_l)) stable_err++;
      if (bus.s_ready !== (!bus.m_valid || (bus.m_last && bus.m_ready))) sready_err++;
      if (bus.m_valid && bus.m_ready) begin
        out_q.push_back(bus.m_data);
        last_q.push_back(bus.m_last);
        cyc_q.push_back(cyc);
      end
      if (bus.s_valid && bus.s_ready) idx++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = bus.m_data;
      prev_l     = bus.m_last;
      cyc++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", bus.m_valid); end
    n_tests++;
    if (bus.m_data !== 16'sd0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", bus.m_data); end
    n_tests++;
    if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %0b want 0", bus.m_last); end
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %0b want 1", bus.s_ready); end
  endtask

  task automatic test_unity_half();
    apply_reset();
    for (int k = 0; k < 4; k++) write_coef(k, 16'sh4000);
    in_q = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0};
    drive_stream(16, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL unity_timeout got %0d outputs want 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== ((i < 4) ? 500 : 0)) begin
        n_fail++; $display("FAIL unity_data[%0d] got %0d want %0d", i, out_q[i], (i < 4) ? 500 : 0);
      end
      n_tests++;
      if (last_q[i] !== ((i % 4) == 3)) begin
        n_fail++; $display("FAIL unity_last[%0d] got %0b want %0b", i, last_q[i], (i % 4) == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    load_phase_order_coefs();
    in_q = '{16'sd128, 16'sd0, 16'sd0, 16'sd0};
    drive_stream(16, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL order_timeout got %0d outputs want 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== i) begin n_fail++; $display("FAIL order_data[%0d] got %0d want %0d", i, out_q[i], i); end
    end
    for (int i = 1; i < 16; i++) begin
      n_tests++;
      if (cyc_q[i] - cyc_q[i-1] !== 1) begin
        n_fail++; $display("FAIL order_bubble[%0d] got gap %0d want 1", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    load_phase_order_coefs();
    in_q = '{16'sd128, 16'sd0, 16'sd0, 16'sd0};
    drive_stream(16, 1'b1);
    n_tests++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %0d outputs want 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== i) begin n_fail++; $display("FAIL bp_data[%0d] got %0d want %0d", i, out_q[i], i); end
    end
    n_tests++;
    if (stable_err !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes want 0", stable_err); end
    n_tests++;
    if (sready_err !== 0) begin n_fail++; $display("FAIL bp_s_ready got %0d bad cycles want 0", sready_err); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < L*TPP; k++) write_coef(k, 16'sh7FFF);
    in_q = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
    drive_stream(16, 1'b0);
    n_tests++;
    if (int'(out_q[0]) !== 32766) begin n_fail++; $display("FAIL sat_pos_first got %0d want 32766", out_q[0]); end
    for (int i = 12; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== 32767) begin n_fail++; $display("FAIL sat_pos[%0d] got %0d want 32767", i, out_q[i]); end
    end
    apply_reset();
    for (int k = 0; k < L*TPP; k++) write_coef(k, 16'sh7FFF);
    in_q = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
    drive_stream(16, 1'b0);
    n_tests++;
    if (int'(out_q[0]) !== -32767) begin n_fail++; $display("FAIL sat_neg_first got %0d want -32767", out_q[0]); end
    for (int i = 12; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== -32768) begin n_fail++; $display("FAIL sat_neg[%0d] got %0d want -32768", i, out_q[i]); end
    end
  endtask

  task automatic test_reset_mid_group();
    apply_reset();
    load_phase_order_coefs();
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = 16'sd128; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sd2) begin
      n_fail++; $display("FAIL midrst_phase2 got valid %0b data %0d want 1/2", bus.m_valid, bus.m_data);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid got %0b want 0", bus.m_valid); end
    n_tests++;
    if (bus.m_data !== 16'sd0) begin n_fail++; $display("FAIL midrst_m_data got %0d want 0", bus.m_data); end
    reset = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_s_ready got %0b want 1", bus.s_ready); end
    load_phase_order_coefs();
    in_q = '{16'sd128, 16'sd0, 16'sd0, 16'sd0};
    drive_stream(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (int'(out_q[i]) !== i) begin n_fail++; $display("FAIL midrst_data[%0d] got %0d want %0d", i, out_q[i], i); end
    end
  endtask

  task automatic test_coef_write_timing();
    apply_reset();
    write_coef(0, 16'sh4000);
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = 16'sd1000; bus.m_ready = 1'b0;
    bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 16'sh2000;
    @(negedge clk);
    bus.s_valid = 1'b0; bus.coef_we = 1'b0;
    #1;
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sd500) begin
      n_fail++; $display("FAIL coefwr_old got valid %0b data %0d want 1/500", bus.m_valid, bus.m_data);
    end
    in_q = '{16'sd1000};
    drive_stream(8, 1'b0);
    n_tests++;
    if (int'(out_q[0]) !== 500) begin n_fail++; $display("FAIL coefwr_held got %0d want 500", out_q[0]); end
    n_tests++;
    if (int'(out_q[4]) !== 250) begin n_fail++; $display("FAIL coefwr_new got %0d want 250", out_q[4]); end
  endtask

  task automatic test_rounding();
    int exp_v;
`ifdef POLY_INTERP_ROUND_EN
    exp_v = 1;
`else
    exp_v = 0;
`endif
    apply_reset();
    write_coef(0, 16'sd1);
    in_q = '{16'sd16384};
    drive_stream(4, 1'b0);
    n_tests++;
    if (int'(out_q[0]) !== exp_v) begin n_fail++; $display("FAIL round_phase0 got %0d want %0d", out_q[0], exp_v); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    test_reset();
    test_unity_half();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_group();
    test_coef_write_timing();
    test_rounding();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
